// File: rtl/add_round_key_stage.sv
// AES AddRoundKey pipeline stage: selects the pre- or post-MixColumns state by round,
// XORs in the round key and buffers the result in a 2-entry skid buffer.
module add_round_key_stage #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iValid,
    output logic         oReady,
    input  logic [127:0] iMixed,
    input  logic [127:0] iShifted,
    input  logic [127:0] iKey,
    input  logic [3:0]   iRound,
    output logic         oValid,
    input  logic         iReady,
    output logic [127:0] oData,
    output logic [3:0]   oRound,
    output logic         oLast,
    output logic         oErr
);

    // Handshake: a word moves upstream->stage on a rising edge with iValid && oReady, and
    // stage->downstream with oValid && iReady. oReady is a flop (skid register empty), so
    // it never depends combinationally on iReady.
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    logic         main_valid, main_valid_d;
    logic [127:0] main_data, main_data_d;
    logic [3:0]   main_round, main_round_d;
    logic         skid_valid, skid_valid_d;
    logic [127:0] skid_data, skid_data_d;
    logic [3:0]   skid_round, skid_round_d;
    logic         ready_q;
    logic         err_q, err_d;

    logic         accept;
    logic         legal;
    logic         take;
    logic         drain;
    logic [127:0] src;
    logic [127:0] word;

    assign accept = iValid && ready_q;
    assign legal  = (iRound <= LAST_ROUND);
    assign take   = accept && legal;
    assign drain  = main_valid && iReady;

    // First and final rounds skip MixColumns, so they key the shifted state.
    assign src  = ((iRound == 4'd0) || (iRound == LAST_ROUND)) ? iShifted : iMixed;
    assign word = src ^ iKey;

    always_comb begin
        main_valid_d = main_valid;
        main_data_d  = main_data;
        main_round_d = main_round;
        skid_valid_d = skid_valid;
        skid_data_d  = skid_data;
        skid_round_d = skid_round;
        err_d        = err_q || (accept && !legal);

        if (skid_valid) begin
            // Input is blocked here because oReady is low whenever the skid is full.
            if (drain) begin
                main_data_d  = skid_data;
                main_round_d = skid_round;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid || drain) begin
            main_valid_d = take;
            if (take) begin
                main_data_d  = word;
                main_round_d = iRound;
            end
        end else if (take) begin
            skid_valid_d = 1'b1;
            skid_data_d  = word;
            skid_round_d = iRound;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_round <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_round <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            main_valid <= main_valid_d;
            main_data  <= main_data_d;
            main_round <= main_round_d;
            skid_valid <= skid_valid_d;
            skid_data  <= skid_data_d;
            skid_round <= skid_round_d;
            ready_q    <= !skid_valid_d;
            err_q      <= err_d;
        end
    end

    assign oReady = ready_q;
    assign oValid = main_valid;
    assign oData  = main_data;
    assign oRound = main_round;
    assign oLast  = (main_round == LAST_ROUND);
    assign oErr   = err_q;

endmodule

// File: doc/add_round_key_stage.md
ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning index of final AES round (AES-128).
REQ-002 SHALL have port iClk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port iRst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port iValid  input  1  upstream word valid.
REQ-005 SHALL have port oReady  output  1  stage can accept a word this cycle.
REQ-006 SHALL have port iMixed  input  128  MixColumns output, MSB-first bytes (byte0 = bits 127:120).
REQ-007 SHALL have port iShifted  input  128  pre-MixColumns state; carries raw plaintext in round 0.
REQ-008 SHALL have port iKey  input  128  round key for iRound.
REQ-009 SHALL have port iRound  input  4  round index of the incoming word.
REQ-010 SHALL have port oValid  output  1  output word valid.
REQ-011 SHALL have port iReady  input  1  downstream accepts the word this cycle.
REQ-012 SHALL have port oData  output  128  round result.
REQ-013 SHALL have port oRound  output  4  round index travelling with oData.
REQ-014 SHALL have port oLast  output  1  high when oRound == NUM_ROUNDS.
REQ-015 SHALL have port oErr  output  1  sticky flag: illegal round index received.

Function
REQ-016 Input transfer SHALL occur only when iValid && oReady at a rising edge; output transfer only when oValid && iReady.
REQ-017 Source select: iRound == 0 or iRound == NUM_ROUNDS -> iShifted; 1..NUM_ROUNDS-1 -> iMixed.
REQ-018 Result SHALL be selected source XOR iKey, bitwise across all 128 bits, no byte reordering.
REQ-019 Storage SHALL be a 2-entry skid buffer: main register (drives outputs) plus one skid register.
REQ-020 Latency SHALL be exactly 1 cycle: word accepted at edge N appears on oData with oValid high after edge N when main register is empty or draining.
REQ-021 oReady SHALL be a registered signal, high when the skid register is empty; never combinationally dependent on iReady.
REQ-022 Accept while main full and not draining -> word goes to skid register, oReady drops next cycle.
REQ-023 Main draining with skid full -> skid moves to main same edge; new input cannot arrive (oReady low).
REQ-024 Simultaneous accept and drain with skid empty -> new word loads main directly, oValid stays high, no bubble.
REQ-025 oData/oRound/oLast SHALL hold stable while oValid && !iReady.
REQ-026 Word order SHALL be preserved; no word dropped or duplicated under any iValid/iReady pattern.
REQ-027 iRound > NUM_ROUNDS on an accepted transfer: word SHALL be discarded (no output), oErr set next cycle and held until reset.
REQ-028 Inputs SHALL be ignored when no transfer occurs; iValid low for any number of cycles SHALL not alter stored words.
REQ-029 Sustained throughput SHALL be one word per cycle when iReady is continuously high.

Reset
REQ-030 iRst_n low SHALL immediately clear: oValid=0, both buffer entries empty, oData=0, oRound=0, oLast=0, oErr=0.
REQ-031 oReady SHALL be 0 while iRst_n is low and become 1 on the first rising edge after deassertion.
REQ-032 Reset asserted mid-operation SHALL discard all buffered words; no stale word appears after release.

Verification
REQ-033 Round 0, iShifted=00112233445566778899aabbccddeeff, iKey=000102030405060708090a0b0c0d0e0f, iReady=1 -> next cycle oData=00102030405060708090a0b0c0d0e0f0, oRound=0, oLast=0.
REQ-034 Round 5, iMixed=FF..FF, iShifted=00..00, iKey=0F0F..0F -> oData=F0F0..F0 (iMixed selected); same with iRound=10 -> oData=0F0F..0F, oLast=1.
REQ-035 Stream rounds 0..10 back-to-back, iReady held low 3 cycles after second accept -> oReady low after 2 accepts, all 11 words emerge in order with correct values, no gaps once iReady=1.
REQ-036 iRound=12 with iValid=1 -> no oValid pulse for it, oErr=1 next cycle, following legal word processes normally, oErr remains 1.
REQ-037 Two words buffered, iRst_n pulsed low asynchronously between edges -> oValid and oErr drop immediately, oReady high one edge after release, no buffered word reappears.
REQ-038 Randomized iValid/iReady over 10,000 cycles against a scoreboard -> zero ordering, loss or data mismatches.
